// File: rtl/axi_lite_reg_responder.sv
// axi_lite_reg_responder
//   AXI4-Lite subordinate terminating one crossbar device port. Holds a bank
//   of NumRegs 32-bit software registers; word 0 is a read-only ID. The bank
//   is driven to hardware on regs_o.
//
// Ports
//   clk_i, rst_ni             clock, asynchronous active-low reset
//   aw*_i / awready_o         write address channel
//   w*_i  / wready_o          write data channel (with byte strobes)
//   bvalid_o, bresp_o, bready_i   write response channel
//   ar*_i / arready_o         read address channel
//   rvalid_o, rdata_o, rresp_o, rready_i   read data channel
//   regs_o                    flat register contents, word k at [k*32 +: 32]
//
// AW and W are independent: whichever arrives first is latched and the write
// commits on the edge that accepts the second one (or on the shared edge when
// both handshake together). Bits above the word index and addr[1:0] are
// ignored; the crossbar does the window decode.

module axi_lite_reg_responder #(
  parameter int unsigned AddrWidth = 32,
  parameter int unsigned DataWidth = 32,
  parameter int unsigned NumRegs   = 16,
  parameter logic [31:0] IdValue   = 32'h7E0E_0001
) (
  input  logic                         clk_i,
  input  logic                         rst_ni,
  input  logic                         awvalid_i,
  output logic                         awready_o,
  input  logic [AddrWidth-1:0]         awaddr_i,
  input  logic                         wvalid_i,
  output logic                         wready_o,
  input  logic [DataWidth-1:0]         wdata_i,
  input  logic [DataWidth/8-1:0]       wstrb_i,
  output logic                         bvalid_o,
  input  logic                         bready_i,
  output logic [1:0]                   bresp_o,
  input  logic                         arvalid_i,
  output logic                         arready_o,
  input  logic [AddrWidth-1:0]         araddr_i,
  output logic                         rvalid_o,
  input  logic                         rready_i,
  output logic [DataWidth-1:0]         rdata_o,
  output logic [1:0]                   rresp_o,
  output logic [NumRegs*DataWidth-1:0] regs_o
);

  localparam int unsigned IdxW  = $clog2(NumRegs);
  localparam int unsigned StrbW = DataWidth / 8;

  localparam logic [1:0] RespOkay   = 2'b00;
  localparam logic [1:0] RespSlvErr = 2'b10;

  logic [IdxW-1:0]      aw_idx, ar_idx, aw_idx_q, wr_idx;
  logic                 aw_held_q, w_held_q;
  logic [DataWidth-1:0] w_data_q, wr_data;
  logic [StrbW-1:0]     w_strb_q, wr_strb;
  logic                 bvalid_q, rvalid_q;
  logic [1:0]           bresp_q, rresp_q;
  logic [DataWidth-1:0] rdata_q, rd_val;
  logic [DataWidth-1:0] regs_q [NumRegs];
  logic                 aw_hs, w_hs, ar_hs, commit, wr_err, rd_err;

  // Address bits outside the word index are intentionally ignored.
  logic unused_addr_bits;
  assign unused_addr_bits = ^{awaddr_i[AddrWidth-1:IdxW+2], awaddr_i[1:0],
                              araddr_i[AddrWidth-1:IdxW+2], araddr_i[1:0]};

  function automatic logic idx_oob(input logic [IdxW-1:0] idx);
    return 32'(idx) >= NumRegs;
  endfunction

  assign aw_idx = awaddr_i[IdxW+1:2];
  assign ar_idx = araddr_i[IdxW+1:2];

  // Write path handshakes and commit selection
  assign awready_o = !aw_held_q && !bvalid_q;
  assign wready_o  = !w_held_q && !bvalid_q;
  assign aw_hs     = awvalid_i && awready_o;
  assign w_hs      = wvalid_i && wready_o;

  // The readies exclude each held flag, so both can never be held at once;
  // a commit always involves at least one live handshake.
  assign commit  = (aw_hs && (w_hs || w_held_q)) || (w_hs && aw_held_q);
  assign wr_idx  = aw_hs ? aw_idx : aw_idx_q;
  assign wr_data = w_hs ? wdata_i : w_data_q;
  assign wr_strb = w_hs ? wstrb_i : w_strb_q;
  assign wr_err  = (wr_idx == '0) || idx_oob(wr_idx);

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      aw_held_q <= 1'b0;
      w_held_q  <= 1'b0;
      aw_idx_q  <= '0;
      w_data_q  <= '0;
      w_strb_q  <= '0;
      bvalid_q  <= 1'b0;
      bresp_q   <= RespOkay;
    end else if (commit) begin
      aw_held_q <= 1'b0;
      w_held_q  <= 1'b0;
      bvalid_q  <= 1'b1;
      bresp_q   <= wr_err ? RespSlvErr : RespOkay;
    end else begin
      if (aw_hs) begin
        aw_held_q <= 1'b1;
        aw_idx_q  <= aw_idx;
      end
      if (w_hs) begin
        w_held_q <= 1'b1;
        w_data_q <= wdata_i;
        w_strb_q <= wstrb_i;
      end
      if (bvalid_q && bready_i) begin
        bvalid_q <= 1'b0;
        bresp_q  <= RespOkay;
      end
    end
  end

  // Register bank; word 0 is never written (the ID is a constant).
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int k = 0; k < NumRegs; k++) regs_q[k] <= '0;
    end else if (commit && !wr_err) begin
      for (int k = 1; k < NumRegs; k++) begin
        if (wr_idx == IdxW'(k)) begin
          for (int b = 0; b < StrbW; b++) begin
            if (wr_strb[b]) regs_q[k][b*8 +: 8] <= wr_data[b*8 +: 8];
          end
        end
      end
    end
  end

  // Read path; the bank is sampled before any same-edge commit lands.
  assign arready_o = !rvalid_q;
  assign ar_hs     = arvalid_i && arready_o;
  assign rd_err    = idx_oob(ar_idx);
  assign rd_val    = (ar_idx == '0) ? IdValue : regs_q[ar_idx];

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rvalid_q <= 1'b0;
      rresp_q  <= RespOkay;
      rdata_q  <= '0;
    end else if (ar_hs) begin
      rvalid_q <= 1'b1;
      rresp_q  <= rd_err ? RespSlvErr : RespOkay;
      rdata_q  <= rd_err ? '0 : rd_val;
    end else if (rvalid_q && rready_i) begin
      rvalid_q <= 1'b0;
      rresp_q  <= RespOkay;
      rdata_q  <= '0;
    end
  end

  assign bvalid_o = bvalid_q;
  assign bresp_o  = bresp_q;
  assign rvalid_o = rvalid_q;
  assign rresp_o  = rresp_q;
  assign rdata_o  = rdata_q;

  for (genvar k = 0; k < NumRegs; k++) begin : g_regs_out
    if (k == 0) begin : g_id
      assign regs_o[k*DataWidth +: DataWidth] = IdValue;
    end else begin : g_rw
      assign regs_o[k*DataWidth +: DataWidth] = regs_q[k];
    end
  end

endmodule

// File: tb/tb_axi_lite_reg_responder.sv
module tb_axi_lite_reg_responder;

  localparam int          NR = 12;
  localparam logic [31:0] ID = 32'h7E0E_0001;

  logic             clk, rst_n;
  logic             awvalid, awready, wvalid, wready, bvalid, bready;
  logic             arvalid, arready, rvalid, rready;
  logic [31:0]      awaddr, wdata, araddr, rdata;
  logic [3:0]       wstrb;
  logic [1:0]       bresp, rresp;
  logic [NR*32-1:0] regs_o;

  int total = 0;
  int bad   = 0;

  logic [31:0] mdl [NR];

  axi_lite_reg_responder #(
    .AddrWidth(32), .DataWidth(32), .NumRegs(NR), .IdValue(ID)
  ) dut (
    .clk_i(clk), .rst_ni(rst_n),
    .awvalid_i(awvalid), .awready_o(awready), .awaddr_i(awaddr),
    .wvalid_i(wvalid), .wready_o(wready), .wdata_i(wdata), .wstrb_i(wstrb),
    .bvalid_o(bvalid), .bready_i(bready), .bresp_o(bresp),
    .arvalid_i(arvalid), .arready_o(arready), .araddr_i(araddr),
    .rvalid_o(rvalid), .rready_i(rready), .rdata_o(rdata), .rresp_o(rresp),
    .regs_o(regs_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- reference model ----------------
  function automatic int idx_of(input logic [31:0] a);
    return int'((a >> 2) % 16);
  endfunction

  function automatic void mdl_reset();
    for (int k = 0; k < NR; k++) mdl[k] = 32'h0;
  endfunction

  function automatic logic [1:0] mdl_write(input logic [31:0] a, input logic [31:0] d,
                                           input logic [3:0] s);
    int i = idx_of(a);
    if (i == 0 || i >= NR) return 2'b10;
    for (int b = 0; b < 4; b++) if (s[b]) mdl[i][b*8 +: 8] = d[b*8 +: 8];
    return 2'b00;
  endfunction

  function automatic void mdl_read(input logic [31:0] a, output logic [31:0] d,
                                   output logic [1:0] r);
    int i = idx_of(a);
    if (i == 0) begin d = ID; r = 2'b00; end
    else if (i >= NR) begin d = 32'h0; r = 2'b10; end
    else begin d = mdl[i]; r = 2'b00; end
  endfunction

  function automatic logic [NR*32-1:0] mdl_flat();
    logic [NR*32-1:0] f;
    for (int k = 0; k < NR; k++) f[k*32 +: 32] = (k == 0) ? ID : mdl[k];
    return f;
  endfunction

  // ---------------- stimulus drivers (called at a negedge) ----------------
  // w_lead > 0: W presented that many cycles before AW; < 0: AW first.
  task automatic axi_write(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s,
                           input int w_lead, output logic [1:0] resp, output int lat,
                           output int held_viol);
    int  c = 0;
    bit  aw_done = 0, w_done = 0;
    int  aw_start = (w_lead > 0) ? w_lead : 0;
    int  w_start  = (w_lead < 0) ? -w_lead : 0;
    held_viol = 0;
    lat = -1;
    resp = 2'bxx;
    while (!(aw_done && w_done) && c < 200) begin
      awvalid = !aw_done && (c >= aw_start);
      awaddr  = a;
      wvalid  = !w_done && (c >= w_start);
      wdata   = d;
      wstrb   = s;
      if (w_done && !aw_done && wready) held_viol++;
      if (aw_done && !w_done && awready) held_viol++;
      if (awvalid && awready) aw_done = 1;
      if (wvalid && wready) w_done = 1;
      @(negedge clk);
      c++;
    end
    awvalid = 1'b0;
    wvalid  = 1'b0;
    if (aw_done && w_done) begin
      for (int k = 1; k <= 20; k++) begin
        if (bvalid) begin lat = k; resp = bresp; break; end
        @(negedge clk);
      end
    end
  endtask

  task automatic b_ack();
    bready = 1'b1;
    @(negedge clk);
    bready = 1'b0;
  endtask

  task automatic axi_read(input logic [31:0] a, output logic [31:0] d, output logic [1:0] r,
                          output int lat);
    int c = 0;
    bit done = 0;
    lat = -1;
    d = 32'hx;
    r = 2'bxx;
    arvalid = 1'b1;
    araddr  = a;
    while (!done && c < 50) begin
      if (arready) done = 1;
      @(negedge clk);
      c++;
    end
    arvalid = 1'b0;
    if (done) begin
      for (int k = 1; k <= 20; k++) begin
        if (rvalid) begin lat = k; d = rdata; r = rresp; break; end
        @(negedge clk);
      end
    end
    if (lat > 0) begin
      rready = 1'b1;
      @(negedge clk);
      rready = 1'b0;
    end
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    mdl_reset();
    @(negedge clk);
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    logic [31:0] d, ed; logic [1:0] r, er; int lat;
    total++;
    if ({awready, wready, arready} !== 3'b111) begin
      bad++; $display("FAIL reset_readies got=%b want=111", {awready, wready, arready});
    end
    total++;
    if ({bvalid, rvalid, bresp, rresp} !== 6'b0 || rdata !== 32'h0) begin
      bad++; $display("FAIL reset_outputs got bv=%b rv=%b br=%b rr=%b rd=%h want zeros",
                      bvalid, rvalid, bresp, rresp, rdata);
    end
    total++;
    if (regs_o !== mdl_flat()) begin
      bad++; $display("FAIL reset_regs got=%h want=%h", regs_o, mdl_flat());
    end
    mdl_read(32'h0, ed, er);
    axi_read(32'h0, d, r, lat);
    total++;
    if (d !== ed || r !== er || lat !== 1) begin
      bad++; $display("FAIL reset_read_id got d=%h r=%b lat=%0d want d=%h r=%b lat=1",
                      d, r, lat, ed, er);
    end
  endtask

  task automatic test_same_cycle_write();
    logic [31:0] d, ed; logic [1:0] r, er, resp, eresp; int lat, hv;
    eresp = mdl_write(32'h8, 32'hDEADBEEF, 4'hF);
    axi_write(32'h8, 32'hDEADBEEF, 4'hF, 0, resp, lat, hv);
    total++;
    if (resp !== eresp || lat !== 1) begin
      bad++; $display("FAIL same_cycle_b got resp=%b lat=%0d want resp=%b lat=1", resp, lat, eresp);
    end
    b_ack();
    total++;
    if (regs_o[2*32 +: 32] !== mdl[2]) begin
      bad++; $display("FAIL same_cycle_word2 got=%h want=%h", regs_o[2*32 +: 32], mdl[2]);
    end
    mdl_read(32'h8, ed, er);
    axi_read(32'h8, d, r, lat);
    total++;
    if (d !== ed || r !== er || lat !== 1) begin
      bad++; $display("FAIL same_cycle_readback got d=%h r=%b lat=%0d want d=%h r=%b",
                      d, r, lat, ed, er);
    end
  endtask

  task automatic test_split_write();
    logic [1:0] resp, eresp; int lat, hv;
    eresp = mdl_write(32'h8, 32'h12345678, 4'b0101);
    axi_write(32'h8, 32'h12345678, 4'b0101, 3, resp, lat, hv);
    total++;
    if (hv !== 0 || resp !== eresp || lat !== 1) begin
      bad++; $display("FAIL w_first got hv=%0d resp=%b lat=%0d want hv=0 resp=%b lat=1",
                      hv, resp, lat, eresp);
    end
    b_ack();
    total++;
    if (regs_o[2*32 +: 32] !== mdl[2]) begin
      bad++; $display("FAIL w_first_word2 got=%h want=%h", regs_o[2*32 +: 32], mdl[2]);
    end
    eresp = mdl_write(32'h24, 32'hCAFEF00D, 4'b1010);
    axi_write(32'h24, 32'hCAFEF00D, 4'b1010, -2, resp, lat, hv);
    total++;
    if (hv !== 0 || resp !== eresp || lat !== 1) begin
      bad++; $display("FAIL aw_first got hv=%0d resp=%b lat=%0d want hv=0 resp=%b lat=1",
                      hv, resp, lat, eresp);
    end
    b_ack();
    total++;
    if (regs_o !== mdl_flat()) begin
      bad++; $display("FAIL aw_first_regs got=%h want=%h", regs_o, mdl_flat());
    end
  endtask

  task automatic test_b_stall();
    logic [1:0] resp, eresp; int lat, hv;
    eresp = mdl_write(32'h10, 32'hA5A55A5A, 4'hF);
    axi_write(32'h10, 32'hA5A55A5A, 4'hF, 0, resp, lat, hv);
    awvalid = 1'b1;
    awaddr  = 32'h14;
    for (int k = 0; k < 5; k++) begin
      total++;
      if (bvalid !== 1'b1 || bresp !== eresp || awready !== 1'b0 || wready !== 1'b0) begin
        bad++; $display("FAIL b_stall_cyc%0d got bv=%b br=%b awr=%b wr=%b want 1 %b 0 0",
                        k, bvalid, bresp, awready, wready, eresp);
      end
      @(negedge clk);
    end
    b_ack();
    total++;
    if (bvalid !== 1'b0 || awready !== 1'b1 || wready !== 1'b1) begin
      bad++; $display("FAIL b_release got bv=%b awr=%b wr=%b want 0 1 1", bvalid, awready, wready);
    end
    @(negedge clk);
    awvalid = 1'b0;
    total++;
    if (awready !== 1'b0 || wready !== 1'b1) begin
      bad++; $display("FAIL aw_after_b got awr=%b wr=%b want 0 1", awready, wready);
    end
    eresp = mdl_write(32'h14, 32'h0BADCAFE, 4'hF);
    wvalid = 1'b1;
    wdata  = 32'h0BADCAFE;
    wstrb  = 4'hF;
    @(negedge clk);
    wvalid = 1'b0;
    total++;
    if (bvalid !== 1'b1 || bresp !== eresp) begin
      bad++; $display("FAIL second_write_b got bv=%b br=%b want 1 %b", bvalid, bresp, eresp);
    end
    b_ack();
    total++;
    if (regs_o !== mdl_flat()) begin
      bad++; $display("FAIL second_write_regs got=%h want=%h", regs_o, mdl_flat());
    end
  endtask

  task automatic test_errors();
    logic [31:0] d, ed; logic [1:0] r, er, resp, eresp; int lat, hv;
    logic [31:0] waddrs [3] = '{32'h0, 32'h30, 32'h8};
    logic [3:0]  wstrbs [3] = '{4'hF, 4'hF, 4'h0};
    logic [31:0] raddrs [5] = '{32'h30, 32'h3C, 32'h40, 32'h2C, 32'h43};
    for (int k = 0; k < 3; k++) begin
      eresp = mdl_write(waddrs[k], 32'hFFFFFFFF, wstrbs[k]);
      axi_write(waddrs[k], 32'hFFFFFFFF, wstrbs[k], 0, resp, lat, hv);
      total++;
      if (resp !== eresp || lat !== 1) begin
        bad++; $display("FAIL err_write%0d addr=%h got resp=%b lat=%0d want resp=%b lat=1",
                        k, waddrs[k], resp, lat, eresp);
      end
      b_ack();
      total++;
      if (regs_o !== mdl_flat()) begin
        bad++; $display("FAIL err_write%0d_regs got=%h want=%h", k, regs_o, mdl_flat());
      end
    end
    for (int k = 0; k < 5; k++) begin
      mdl_read(raddrs[k], ed, er);
      axi_read(raddrs[k], d, r, lat);
      total++;
      if (d !== ed || r !== er || lat !== 1) begin
        bad++; $display("FAIL err_read%0d addr=%h got d=%h r=%b lat=%0d want d=%h r=%b",
                        k, raddrs[k], d, r, lat, ed, er);
      end
    end
  endtask

  task automatic test_same_edge_rw();
    logic [31:0] d, ed, old_v; logic [1:0] r, er, resp, eresp; int lat, hv;
    eresp = mdl_write(32'h4, 32'h1111, 4'hF);
    axi_write(32'h4, 32'h1111, 4'hF, 0, resp, lat, hv);
    b_ack();
    mdl_read(32'h4, old_v, er);
    eresp = mdl_write(32'h4, 32'h2222, 4'hF);
    awvalid = 1'b1; awaddr = 32'h4;
    wvalid  = 1'b1; wdata  = 32'h2222; wstrb = 4'hF;
    arvalid = 1'b1; araddr = 32'h4;
    @(negedge clk);
    awvalid = 1'b0; wvalid = 1'b0; arvalid = 1'b0;
    for (int k = 0; k < 3; k++) begin
      total++;
      if (rvalid !== 1'b1 || rdata !== old_v || rresp !== er || arready !== 1'b0) begin
        bad++; $display("FAIL same_edge_r_cyc%0d got rv=%b d=%h r=%b arr=%b want 1 %h %b 0",
                        k, rvalid, rdata, rresp, arready, old_v, er);
      end
      @(negedge clk);
    end
    total++;
    if (bvalid !== 1'b1 || bresp !== eresp) begin
      bad++; $display("FAIL same_edge_b got bv=%b br=%b want 1 %b", bvalid, bresp, eresp);
    end
    rready = 1'b1; bready = 1'b1;
    @(negedge clk);
    rready = 1'b0; bready = 1'b0;
    total++;
    if (rvalid !== 1'b0 || bvalid !== 1'b0 || arready !== 1'b1) begin
      bad++; $display("FAIL same_edge_release got rv=%b bv=%b arr=%b want 0 0 1", rvalid, bvalid, arready);
    end
    mdl_read(32'h4, ed, er);
    axi_read(32'h4, d, r, lat);
    total++;
    if (d !== ed || r !== er || lat !== 1) begin
      bad++; $display("FAIL same_edge_readback got d=%h r=%b lat=%0d want d=%h r=%b", d, r, lat, ed, er);
    end
  endtask

  task automatic test_random();
    logic [31:0] a, d, ed, dat; logic [1:0] r, er, resp, eresp; logic [3:0] s; int lat, hv, lead;
    for (int n = 0; n < 60; n++) begin
      a = ($urandom_range(0, 15) << 2) | $urandom_range(0, 3) | ($urandom_range(0, 3) << 6);
      if ($urandom_range(0, 1) == 1) begin
        dat  = $urandom;
        s    = 4'($urandom_range(0, 15));
        lead = $urandom_range(0, 4) - 2;
        eresp = mdl_write(a, dat, s);
        axi_write(a, dat, s, lead, resp, lat, hv);
        total++;
        if (resp !== eresp || lat !== 1 || hv !== 0) begin
          bad++; $display("FAIL rnd_write%0d addr=%h got resp=%b lat=%0d hv=%0d want resp=%b lat=1 hv=0",
                          n, a, resp, lat, hv, eresp);
        end
        repeat ($urandom_range(0, 2)) @(negedge clk);
        b_ack();
        total++;
        if (regs_o !== mdl_flat()) begin
          bad++; $display("FAIL rnd_regs%0d got=%h want=%h", n, regs_o, mdl_flat());
        end
      end else begin
        mdl_read(a, ed, er);
        axi_read(a, d, r, lat);
        total++;
        if (d !== ed || r !== er || lat !== 1) begin
          bad++; $display("FAIL rnd_read%0d addr=%h got d=%h r=%b lat=%0d want d=%h r=%b",
                          n, a, d, r, lat, ed, er);
        end
      end
    end
  endtask

  task automatic test_reset_mid();
    logic [1:0] resp, eresp; int lat, hv;
    eresp = mdl_write(32'h18, 32'h55AA55AA, 4'hF);
    axi_write(32'h18, 32'h55AA55AA, 4'hF, 0, resp, lat, hv);
    total++;
    if (bvalid !== 1'b1) begin
      bad++; $display("FAIL pre_reset_bvalid got=%b want=1", bvalid);
    end
    rst_n = 1'b0;
    mdl_reset();
    #1;
    total++;
    if (bvalid !== 1'b0 || rvalid !== 1'b0 || regs_o !== mdl_flat()) begin
      bad++; $display("FAIL mid_reset got bv=%b rv=%b regs=%h want 0 0 %h", bvalid, rvalid, regs_o, mdl_flat());
    end
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    // W held, then reset: the held data must be discarded.
    wvalid = 1'b1; wdata = 32'hFEEDFACE; wstrb = 4'hF;
    @(negedge clk);
    wvalid = 1'b0;
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    total++;
    if (wready !== 1'b1 || awready !== 1'b1) begin
      bad++; $display("FAIL held_w_cleared got wr=%b awr=%b want 1 1", wready, awready);
    end
    awvalid = 1'b1; awaddr = 32'h1C;
    @(negedge clk);
    awvalid = 1'b0;
    repeat (3) @(negedge clk);
    total++;
    if (bvalid !== 1'b0 || regs_o !== mdl_flat()) begin
      bad++; $display("FAIL no_partial_write got bv=%b regs=%h want 0 %h", bvalid, regs_o, mdl_flat());
    end
    eresp = mdl_write(32'h1C, 32'h01020304, 4'hF);
    wvalid = 1'b1; wdata = 32'h01020304; wstrb = 4'hF;
    @(negedge clk);
    wvalid = 1'b0;
    total++;
    if (bvalid !== 1'b1 || bresp !== eresp) begin
      bad++; $display("FAIL post_reset_write got bv=%b br=%b want 1 %b", bvalid, bresp, eresp);
    end
    b_ack();
    total++;
    if (regs_o !== mdl_flat()) begin
      bad++; $display("FAIL post_reset_regs got=%h want=%h", regs_o, mdl_flat());
    end
  endtask

  initial begin
    rst_n = 1'b0;
    awvalid = 1'b0; awaddr = '0;
    wvalid = 1'b0; wdata = '0; wstrb = '0;
    bready = 1'b0;
    arvalid = 1'b0; araddr = '0;
    rready = 1'b0;
    mdl_reset();
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    test_reset();
    test_same_cycle_write();
    test_split_write();
    test_b_stall();
    test_errors();
    test_same_edge_rw();
    test_random();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
